// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: execute commands and branch types.
// Used by ID-stage decode and by the execute stage.
package mips_pkg;

    localparam logic [3:0] EXE_CMD_ADD = 4'b0000;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0010;
    localparam logic [3:0] EXE_CMD_AND = 4'b0100;
    localparam logic [3:0] EXE_CMD_OR  = 4'b0101;
    localparam logic [3:0] EXE_CMD_NOR = 4'b0110;
    localparam logic [3:0] EXE_CMD_XOR = 4'b0111;
    localparam logic [3:0] EXE_CMD_SLL = 4'b1000;
    localparam logic [3:0] EXE_CMD_SRA = 4'b1001;
    localparam logic [3:0] EXE_CMD_SRL = 4'b1010;
    localparam logic [3:0] EXE_CMD_MUL = 4'b1100;
    localparam logic [3:0] EXE_CMD_NOP = 4'b1111;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef enum logic {
        StIdle,
        StBusy
    } mul_state_e;

endpackage

// File: rtl/iter_multiplier.sv
// Shift-add multiplier: one partial product per cycle, low 32 bits of the product.
// 'last' marks the final iteration; 'product' is valid combinationally in that cycle.
module iter_multiplier
    import mips_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        last,
    output logic [31:0] product
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES);

    mul_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       mcand_q, mcand_d;
    logic [31:0]       mplier_q, mplier_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       partial;

    assign partial = mplier_q[0] ? mcand_q : 32'd0;
    assign busy    = (state_q == StBusy);
    assign last    = busy && (cnt_q == CntW'(MUL_CYCLES - 1));
    // Final partial term is folded in here so the result is ready in the last cycle.
    assign product = acc_q + partial;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 32'd0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU, iterative multiply with upstream stall,
// branch resolution and the EX/MEM pipeline register.
module exe_stage
    import mips_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dest_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] reg1_in,
    input  logic [31:0] reg2_in,
    input  logic [31:0] pc_in,
    input  logic [1:0]  branch_type_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        wb_en_in,
    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [31:0] alu_res_out,
    output logic [31:0] st_val_out,
    output logic [4:0]  dest_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic        wb_en_out
);

    logic        is_mul, mul_start, mul_busy, mul_last;
    logic [31:0] mul_product;
    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic        br_cond;

    // Control of the in-flight multiply, held while upstream is stalled
    logic [4:0]  mdest_q, mdest_d;
    logic [31:0] mst_q, mst_d;
    logic        mmr_q, mmr_d, mmw_q, mmw_d, mwb_q, mwb_d;

    // EX/MEM register
    logic [31:0] alu_q, alu_d, st_q, st_d;
    logic [4:0]  dest_q, dest_d;
    logic        mr_q, mr_d, mw_q, mw_d, wb_q, wb_d;

    assign is_mul    = (exe_cmd_in == EXE_CMD_MUL);
    assign mul_start = !mul_busy && is_mul;
    assign shamt     = reg2_in[4:0];

    iter_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (reg1_in),
        .b       (reg2_in),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );

    always_comb begin
        alu_res = 32'd0;
        case (exe_cmd_in)
            EXE_CMD_ADD: alu_res = reg1_in + reg2_in;
            EXE_CMD_SUB: alu_res = reg1_in - reg2_in;
            EXE_CMD_AND: alu_res = reg1_in & reg2_in;
            EXE_CMD_OR:  alu_res = reg1_in | reg2_in;
            EXE_CMD_NOR: alu_res = ~(reg1_in | reg2_in);
            EXE_CMD_XOR: alu_res = reg1_in ^ reg2_in;
            EXE_CMD_SLL: alu_res = reg1_in << shamt;
            EXE_CMD_SRA: alu_res = $signed(reg1_in) >>> shamt;
            EXE_CMD_SRL: alu_res = reg1_in >> shamt;
            default:     alu_res = 32'd0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (branch_type_in)
            BR_BEZ:  br_cond = (reg1_in == 32'd0);
            BR_BNE:  br_cond = (reg1_in != reg2_in);
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    // Gated by rst so neither upstream control asserts while the stage is held in reset
    assign branch_taken = rst && !mul_busy && br_cond;
    assign branch_addr  = pc_in + (imm_in << 2);
    assign stall        = rst && ((!mul_busy && is_mul) || (mul_busy && !mul_last));

    always_comb begin
        alu_d   = 32'd0;
        st_d    = 32'd0;
        dest_d  = 5'd0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        wb_d    = 1'b0;
        mdest_d = mdest_q;
        mst_d   = mst_q;
        mmr_d   = mmr_q;
        mmw_d   = mmw_q;
        mwb_d   = mwb_q;
        if (mul_busy) begin
            if (mul_last) begin
                alu_d  = mul_product;
                st_d   = mst_q;
                dest_d = mdest_q;
                mr_d   = mmr_q;
                mw_d   = mmw_q;
                wb_d   = mwb_q;
            end
        end else if (is_mul) begin
            mdest_d = dest_in;
            mst_d   = reg2_in;
            mmr_d   = mem_r_en_in;
            mmw_d   = mem_w_en_in;
            mwb_d   = wb_en_in;
        end else begin
            alu_d  = alu_res;
            st_d   = reg2_in;
            dest_d = dest_in;
            mr_d   = mem_r_en_in;
            mw_d   = mem_w_en_in;
            wb_d   = wb_en_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_q   <= 32'd0;
            st_q    <= 32'd0;
            dest_q  <= 5'd0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            wb_q    <= 1'b0;
            mdest_q <= 5'd0;
            mst_q   <= 32'd0;
            mmr_q   <= 1'b0;
            mmw_q   <= 1'b0;
            mwb_q   <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            st_q    <= st_d;
            dest_q  <= dest_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            wb_q    <= wb_d;
            mdest_q <= mdest_d;
            mst_q   <= mst_d;
            mmr_q   <= mmr_d;
            mmw_q   <= mmw_d;
            mwb_q   <= mwb_d;
        end
    end

    assign alu_res_out  = alu_q;
    assign st_val_out   = st_q;
    assign dest_out     = dest_q;
    assign mem_r_en_out = mr_q;
    assign mem_w_en_out = mw_q;
    assign wb_en_out    = wb_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector tables, random ALU/branch/multiply
// traffic against a behavioural model, and reset/multiply corner sequences.
module tb_exe_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dest_in;
    logic [31:0] imm_in, reg1_in, reg2_in, pc_in;
    logic [1:0]  branch_type_in;
    logic [3:0]  exe_cmd_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in;
    logic        stall, branch_taken;
    logic [31:0] branch_addr, alu_res_out, st_val_out;
    logic [4:0]  dest_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out;

    int n_vec = 0;
    int n_err = 0;

    exe_stage dut (
        .clk            (clk),
        .rst            (rst),
        .dest_in        (dest_in),
        .imm_in         (imm_in),
        .reg1_in        (reg1_in),
        .reg2_in        (reg2_in),
        .pc_in          (pc_in),
        .branch_type_in (branch_type_in),
        .exe_cmd_in     (exe_cmd_in),
        .mem_r_en_in    (mem_r_en_in),
        .mem_w_en_in    (mem_w_en_in),
        .wb_en_in       (wb_en_in),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .alu_res_out    (alu_res_out),
        .st_val_out     (st_val_out),
        .dest_out       (dest_out),
        .mem_r_en_out   (mem_r_en_out),
        .mem_w_en_out   (mem_w_en_out),
        .wb_en_out      (wb_en_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [1:0]  br;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        taken;
    } br_vec_t;

    // Reference ALU written directly from the command semantics
    function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (cmd)
            4'd0:    return a + b;
            4'd2:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return ~(a | b);
            4'd7:    return a ^ b;
            4'd8:    return a * (32'd1 << sh);
            4'd9:    return 32'($signed(a) >>> sh);
            4'd10:   return a / (32'd1 << sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] br, input logic [4:0] dest, input logic mr,
                         input logic mw, input logic wb);
        exe_cmd_in     = cmd;
        reg1_in        = a;
        reg2_in        = b;
        branch_type_in = br;
        dest_in        = dest;
        mem_r_en_in    = mr;
        mem_w_en_in    = mw;
        wb_en_in       = wb;
    endtask

    task automatic chk_exmem_zero(input string tag);
        chk({tag, "_alu"}, alu_res_out, 32'd0);
        chk({tag, "_st"}, st_val_out, 32'd0);
        chk({tag, "_dest"}, 32'(dest_out), 32'd0);
        chk({tag, "_ctl"}, {29'd0, mem_r_en_out, mem_w_en_out, wb_en_out}, 32'd0);
    endtask

    // Presents a MUL, follows it to completion and checks stall length, bubbles and product.
    // With hold=0 the inputs are scrambled during BUSY (including BNE with unequal operands).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit hold,
                           input logic [4:0] dest, input string tag);
        logic [31:0] exp_p;
        int          hi, bub_bad, br_bad;
        logic [31:0] g;
        exp_p   = a * b;
        hi      = 0;
        bub_bad = 0;
        br_bad  = 0;
        drive(EXE_CMD_MUL, a, b, BR_NONE, dest, 1'b0, 1'b0, 1'b1);
        #1;
        if (stall) hi++;
        for (int k = 0; k < 64; k++) begin
            step();
            if (!hold) begin
                g = $urandom;
                drive(4'($urandom), g, ~g, BR_BNE, 5'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom));
                #1;
            end
            if (branch_taken) br_bad++;
            if (alu_res_out != 32'd0 || wb_en_out || mem_r_en_out || mem_w_en_out ||
                dest_out != 5'd0) bub_bad++;
            if (!stall) break;
            hi++;
        end
        chk({tag, "_stall_cycles"}, 32'(hi), 32'd32);
        chk({tag, "_bubbles"}, 32'(bub_bad), 32'd0);
        chk({tag, "_br_in_busy"}, 32'(br_bad), 32'd0);
        step();
        chk({tag, "_product"}, alu_res_out, exp_p);
        chk({tag, "_wb"}, 32'(wb_en_out), 32'd1);
        chk({tag, "_dest"}, 32'(dest_out), 32'(dest));
    endtask

    alu_vec_t    atbl[12];
    br_vec_t     btbl[6];
    logic [31:0] ra, rb, rpc, rimm, exp_v;
    logic [3:0]  rcmd;
    logic [1:0]  rbr;
    logic [4:0]  rdest;
    logic        rmr, rmw, rwb, exp_t;
    int          seen;

    initial begin
        atbl[0]  = '{EXE_CMD_ADD, 32'd5, 32'd7, 32'd12};
        atbl[1]  = '{EXE_CMD_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE};
        atbl[2]  = '{EXE_CMD_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF};
        atbl[3]  = '{EXE_CMD_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000};
        atbl[4]  = '{EXE_CMD_SLL, 32'd1, 32'd31, 32'h8000_0000};
        atbl[5]  = '{EXE_CMD_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000};
        atbl[6]  = '{EXE_CMD_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        atbl[7]  = '{EXE_CMD_OR,  32'hF000_0001, 32'h000F_0010, 32'hF00F_0011};
        atbl[8]  = '{EXE_CMD_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        atbl[9]  = '{EXE_CMD_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1};
        atbl[10] = '{4'b0011, 32'd9, 32'd9, 32'd0};
        atbl[11] = '{EXE_CMD_SLL, 32'h0000_00FF, 32'h0000_0124, 32'h0000_0FF0};

        btbl[0] = '{BR_BEZ,  32'd0, 32'd3, 1'b1};
        btbl[1] = '{BR_BEZ,  32'd5, 32'd3, 1'b0};
        btbl[2] = '{BR_BNE,  32'd7, 32'd7, 1'b0};
        btbl[3] = '{BR_BNE,  32'd7, 32'd8, 1'b1};
        btbl[4] = '{BR_JMP,  32'd9, 32'd9, 1'b1};
        btbl[5] = '{BR_NONE, 32'd0, 32'd0, 1'b0};

        // Reset held with a MUL and a JMP on the inputs
        rst    = 1'b0;
        pc_in  = $urandom;
        imm_in = $urandom;
        drive(EXE_CMD_MUL, $urandom, $urandom, BR_JMP, 5'($urandom), 1'b1, 1'b1, 1'b1);
        repeat (3) step();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_branch", 32'(branch_taken), 32'd0);
        chk_exmem_zero("rst");
        drive(EXE_CMD_NOP, 32'd0, 32'd0, BR_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_stall", 32'(stall), 32'd0);
        chk_exmem_zero("rel");

        // Directed ALU vectors
        for (int i = 0; i < 12; i++) begin
            drive(atbl[i].cmd, atbl[i].a, atbl[i].b, BR_NONE, 5'(i + 1), 1'b0, 1'b0, 1'b1);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            step();
            chk($sformatf("vec%0d_alu", i), alu_res_out, atbl[i].exp);
            chk($sformatf("vec%0d_wb", i), 32'(wb_en_out), 32'd1);
            chk($sformatf("vec%0d_dest", i), 32'(dest_out), 32'(i + 1));
            chk($sformatf("vec%0d_st", i), st_val_out, atbl[i].b);
        end

        // Directed branches
        pc_in  = 32'h100;
        imm_in = 32'hFFFF_FFFE;
        for (int i = 0; i < 6; i++) begin
            drive(EXE_CMD_NOP, btbl[i].r1, btbl[i].r2, btbl[i].br, 5'd0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("br%0d_taken", i), 32'(branch_taken), 32'(btbl[i].taken));
            chk($sformatf("br%0d_addr", i), branch_addr, 32'hF8);
            step();
            chk($sformatf("br%0d_wb", i), 32'(wb_en_out), 32'd0);
        end

        // Random single-cycle traffic
        for (int i = 0; i < 60; i++) begin
            rcmd = 4'($urandom_range(0, 15));
            if (rcmd == EXE_CMD_MUL) rcmd = EXE_CMD_ADD;
            ra    = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rb    = $urandom;
            rdest = 5'($urandom);
            rmr   = 1'($urandom);
            rmw   = 1'($urandom);
            rwb   = 1'($urandom);
            drive(rcmd, ra, rb, BR_NONE, rdest, rmr, rmw, rwb);
            exp_v = ref_alu(rcmd, ra, rb);
            step();
            chk($sformatf("rnd%0d_alu", i), alu_res_out, exp_v);
            chk($sformatf("rnd%0d_st", i), st_val_out, rb);
            chk($sformatf("rnd%0d_ctl", i),
                {24'd0, dest_out, mem_r_en_out, mem_w_en_out, wb_en_out},
                {24'd0, rdest, rmr, rmw, rwb});
        end

        // Random branches
        for (int i = 0; i < 20; i++) begin
            rbr   = 2'($urandom);
            ra    = (i % 3 == 0) ? 32'd0 : $urandom;
            rb    = (i % 5 == 0) ? ra : $urandom;
            rpc   = $urandom;
            rimm  = $urandom;
            pc_in = rpc;
            imm_in = rimm;
            drive(EXE_CMD_NOP, ra, rb, rbr, 5'd0, 1'b0, 1'b0, 1'b0);
            exp_t = (rbr == 2'd1 && ra == 0) || (rbr == 2'd2 && ra != rb) || (rbr == 2'd3);
            #1;
            chk($sformatf("rbr%0d_taken", i), 32'(branch_taken), 32'(exp_t));
            chk($sformatf("rbr%0d_addr", i), branch_addr, rpc + rimm * 4);
            step();
        end

        // Multiply with held inputs, then an ADD completes one edge later
        run_mul(32'h0001_0003, 32'h0002_0005, 1'b1, 5'd9, "mul_spec");
        drive(EXE_CMD_ADD, 32'd20, 32'd22, BR_NONE, 5'd4, 1'b0, 1'b0, 1'b1);
        #1;
        chk("post_mul_stall", 32'(stall), 32'd0);
        step();
        chk("post_mul_add", alu_res_out, 32'd42);
        chk("post_mul_dest", 32'(dest_out), 32'd4);

        // Multiply followed by a BNE waiting upstream
        pc_in  = 32'h100;
        imm_in = 32'hFFFF_FFFE;
        run_mul(32'd1234, 32'd5678, 1'b0, 5'd3, "mul_bne");
        drive(EXE_CMD_NOP, 32'd1, 32'd2, BR_BNE, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mul_bne_taken", 32'(branch_taken), 32'd1);
        chk("mul_bne_addr", branch_addr, 32'hF8);
        step();

        // Random multiplies with scrambled inputs during BUSY
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom, $urandom, 1'b0, 5'($urandom_range(1, 31)), $sformatf("rmul%0d", i));
            drive(EXE_CMD_NOP, 32'd0, 32'd0, BR_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Reset asserted at iteration 10 of a multiply
        drive(EXE_CMD_MUL, 32'h0000_1234, 32'h0000_0010, BR_JMP, 5'd7, 1'b0, 1'b0, 1'b1);
        repeat (11) step();
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_branch", 32'(branch_taken), 32'd0);
        chk_exmem_zero("abort");
        drive(EXE_CMD_NOP, 32'd0, 32'd0, BR_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        rst  = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (alu_res_out == 32'h0001_2340 || wb_en_out || stall) seen++;
        end
        chk("abort_no_product", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It is the consumer of the ID/EX pipeline register outputs.
- Performs single-cycle ALU operations and a 33-cycle iterative multiply, and resolves branches.
- Drives `stall` back upstream so the ID/EX register and earlier stages hold while the multiply runs.
- Registers its results into the EX/MEM stage outputs.

Parameters:
- `MUL_CYCLES`, 32, number of shift-add iterations in the multiplier. Fixed to data width and not intended to be overridden.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `dest_in` input 5: destination register from ID/EX.
- `imm_in` input 32: sign-extended immediate.
- `reg1_in` input 32: operand A.
- `reg2_in` input 32: operand B, also the store data.
- `pc_in` input 32: PC+4 of the instruction.
- `branch_type_in` input 2: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `exe_cmd_in` input 4: ALU command.
- `mem_r_en_in`, `mem_w_en_in`, `wb_en_in` input 1 each: control bits from ID/EX.
- `stall` output 1: hold the ID/EX register and earlier stages this cycle.
- `branch_taken` output 1: redirect IF and flush IF/ID and ID/EX. Combinational.
- `branch_addr` output 32: branch target. Combinational.
- `alu_res_out` output 32: EX/MEM ALU result.
- `st_val_out` output 32: EX/MEM store data.
- `dest_out` output 5, `mem_r_en_out`, `mem_w_en_out`, `wb_en_out` output 1 each: EX/MEM control.

Behaviour:
- Reset: `rst`=0 asynchronously clears every registered output to 0, sets state to IDLE and clears the iteration counter. `stall` and `branch_taken` read 0 while in reset.
- exe_cmd encodings:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL, 1100 MUL, 1111 NOP.
  - Shift amount is `reg2_in[4:0]` and the shifted value is `reg1_in`.
  - ALU operand B is always `reg2_in`; ID has already muxed the immediate into it.
  - Arithmetic wraps mod 2^32 with no overflow flag.
  - Undefined codes produce result 0.
- Single-cycle ops (state IDLE, cmd != MUL): the result and all control/dest/`st_val` values are captured on the next rising edge. Latency is 1. `stall`=0.
- FSM states: IDLE and BUSY.
  - IDLE with cmd==MUL: `stall`=1. At the edge, latch multiplicand=`reg1_in`, multiplier=`reg2_in`, acc=0, dest and control bits, count=0; go to BUSY. The EX/MEM register captures a bubble (all enables 0, dest 0, data 0).
  - BUSY: each edge, acc += multiplicand if multiplier[0], then multiplicand <<= 1, multiplier >>= 1, count++. While count < 31, `stall`=1 and EX/MEM captures a bubble.
  - BUSY with count==31: `stall`=0. At the edge, EX/MEM captures the final product (acc + last partial term, low 32 bits) with the latched control bits; go to IDLE.
  - Total: `stall` is high for 32 consecutive cycles and the product appears in EX/MEM 33 edges after the MUL is presented.
- The next instruction presented after MUL completion is processed normally in the following cycle.
- Branch resolution, evaluated only in IDLE:
  - Taken when BEZ and `reg1_in`==0, BNE and `reg1_in`!=`reg2_in`, or JMP.
  - `branch_addr` = `pc_in` + (`imm_in` << 2), mod 2^32.
  - `branch_taken` is forced to 0 in BUSY.
- A branch instruction still passes its own control bits to EX/MEM; ID supplies wb/mem enables of 0 for branches.
- Reset asserted mid-multiply aborts it: state returns to IDLE and no partial result is written.
- Inputs are ignored during BUSY; upstream holds them stable because `stall` is high.

Decomposition:
- Shared package `mips_pkg` holds the EXE_CMD_* 4-bit constants and the BR_NONE/BR_BEZ/BR_BNE/BR_JMP 2-bit constants. ID-stage decode uses the same package.
- One sub-module, `iter_multiplier`:
  - Interface: `start`, `a`, `b`, `busy`, `last`, `product`.
  - Contains the counter and the shift-add datapath.
  - The ALU, branch logic and EX/MEM register remain in `exe_stage`.

Test Plan:
- Reset: hold `rst`=0 with random inputs, then release → all outputs 0 and `stall`=0; the first ADD of 5+7 gives `alu_res_out`=12 after one edge.
- ALU sweep: SUB 3−5 → 0xFFFFFFFE; NOR 0,0 → 0xFFFFFFFF; SRA 0x80000000 by 4 → 0xF8000000; SLL 1 by 31 → 0x80000000. Each appears one edge later with `wb_en_out` passed through.
- MUL of 0x00010003 × 0x00020005:
  - `stall` high for exactly 32 cycles; EX/MEM shows bubbles meanwhile.
  - On edge 33, `alu_res_out`=0x000B000F (low word) and `wb_en_out`=1.
  - The next ADD completes normally one cycle later.
- Branches with `pc_in`=0x100 and `imm_in`=0xFFFFFFFE:
  - BEZ with `reg1_in`=0 → taken, `branch_addr`=0xF8.
  - BNE with equal operands → not taken.
  - JMP → taken.
- MUL followed by BNE held upstream: `branch_taken` stays 0 through BUSY and asserts only in the cycle after completion.
- Assert `rst` low at iteration 10 of a MUL → state IDLE, `stall`=0, all EX/MEM outputs 0, and no product ever appears.
